// File: rtl/inst_mem_server.sv
// Instruction-memory responder: word-organised program store with a load port and a
// request/response fetch handshake that inserts WAIT_CYCLES wait states per fetch.
module inst_mem_server #(
   parameter int DEPTH_LOG2  = 6,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Req,
   input  logic [31:0]           Addr,
   output logic                  Ready,
   output logic                  Rsp_Valid,
   output logic [31:0]           Inst,
   output logic                  Err,
   input  logic                  Load_En,
   input  logic [DEPTH_LOG2-1:0] Load_Addr,
   input  logic [31:0]           Load_Data
);

   localparam int         DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   logic [31:0]           mem_q [DEPTH];
   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [31:0]           rd_data_q, rd_data_d;
   logic                  rd_err_q, rd_err_d;
   logic                  ready_q, ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [31:0]           inst_q, inst_d;
   logic                  err_q, err_d;

   logic                  accept_s;
   logic                  addr_err_s;
   logic [DEPTH_LOG2-1:0] word_idx_s;
   logic [31:0]           word_s;

   // Address decode and store read; the read sees pre-edge contents (read-before-write)
   always_comb begin
      accept_s   = Req & ready_q;
      addr_err_s = (Addr[1:0] != 2'b00) | (|Addr[31:DEPTH_LOG2+2]);
      word_idx_s = Addr[DEPTH_LOG2+1:2];
      if (addr_err_s) begin
         word_s = 32'h0000_0000;
      end else begin
         word_s = mem_q[word_idx_s];
      end
   end

   // Program-load port; contents deliberately survive Reset
   always_ff @(posedge Clock) begin
      if (Load_En && !Reset) begin
         mem_q[Load_Addr] <= Load_Data;
      end
   end

   // Fetch FSM next-state and response data selection
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_data_d = rd_data_q;
      rd_err_d  = rd_err_q;
      inst_d    = inst_q;
      err_d     = err_q;
      case (state_q)
         ST_IDLE, ST_RESP: begin
            if (accept_s) begin
               rd_data_d = word_s;
               rd_err_d  = addr_err_s;
               if (WAIT_INIT == 4'd0) begin
                  // No wait states: the response is presented straight from this read
                  state_d = ST_RESP;
                  inst_d  = word_s;
                  err_d   = addr_err_s;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = ST_RESP;
               inst_d  = rd_data_q;
               err_d   = rd_err_q;
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
      ready_d     = (state_d != ST_WAIT);
      rsp_valid_d = (state_d == ST_RESP);
   end

   // State and registered output update with synchronous reset
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         rd_data_q   <= 32'h0000_0000;
         rd_err_q    <= 1'b0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         inst_q      <= 32'h0000_0000;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rd_data_q   <= rd_data_d;
         rd_err_q    <= rd_err_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         inst_q      <= inst_d;
         err_q       <= err_d;
      end
   end

   assign Ready     = ready_q;
   assign Rsp_Valid = rsp_valid_q;
   assign Inst      = inst_q;
   assign Err       = err_q;

endmodule

// File: tb/tb_inst_mem_server.sv
// Directed bench for inst_mem_server: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance
// sharing clock, reset and load port.
module tb_inst_mem_server;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_en;
   logic [5:0]  ld_addr;
   logic [31:0] ld_data;

   logic        req, ready, rsp_valid, err;
   logic [31:0] addr, inst;
   logic        req0, ready0, rsp_valid0, err0;
   logic [31:0] addr0, inst0;

   int total = 0;
   int bad   = 0;

   logic [31:0] prog [4];

   always #5 clk = ~clk;

   inst_mem_server #(.DEPTH_LOG2(6), .WAIT_CYCLES(2)) dut (
      .Clock(clk), .Reset(rst), .Req(req), .Addr(addr), .Ready(ready),
      .Rsp_Valid(rsp_valid), .Inst(inst), .Err(err),
      .Load_En(ld_en), .Load_Addr(ld_addr), .Load_Data(ld_data)
   );

   inst_mem_server #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) dut0 (
      .Clock(clk), .Reset(rst), .Req(req0), .Addr(addr0), .Ready(ready0),
      .Rsp_Valid(rsp_valid0), .Inst(inst0), .Err(err0),
      .Load_En(ld_en), .Load_Addr(ld_addr), .Load_Data(ld_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one fetch from an idle responder and check latency, data, error and single pulse.
   task automatic fetch_check(input string tag, input logic [31:0] a,
                              input logic [31:0] exp_inst, input logic exp_err);
      int  n;
      bit  seen;
      req  = 1'b1;
      addr = a;
      tick();
      req  = 1'b0;
      addr = 32'hFFFF_FFF0;
      n    = 1;
      seen = 1'b0;
      while (!seen && n < 12) begin
         if (rsp_valid) begin
            seen = 1'b1;
         end else begin
            tick();
            n++;
         end
      end
      chk({tag, "_lat"}, 32'(n), 32'd3);
      chk({tag, "_inst"}, inst, exp_inst);
      chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
      tick();
      chk({tag, "_pulse_end"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_err_hold"}, {31'd0, err}, {31'd0, exp_err});
   endtask

   initial begin
      int          n_rsp;
      int          last_cyc;
      int          n_acc;
      bit          rdy_before;
      logic [31:0] exp0 [4];

      prog[0] = 32'h2008_0005;
      prog[1] = 32'h2009_0003;
      prog[2] = 32'h0109_5020;
      prog[3] = 32'h0800_0000;

      rst = 1'b1; ld_en = 1'b0; ld_addr = 6'd0; ld_data = 32'h0;
      req = 1'b0; addr = 32'h0; req0 = 1'b0; addr0 = 32'h0;
      tick();
      tick();
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_err", {31'd0, err}, 32'd0);
      rst = 1'b0;
      tick();
      chk("ready_after_rst", {31'd0, ready}, 32'd1);

      for (int i = 0; i < 4; i++) begin
         ld_en = 1'b1; ld_addr = 6'(i); ld_data = prog[i];
         tick();
      end
      ld_en = 1'b1; ld_addr = 6'd63; ld_data = 32'h1234_5678;
      tick();
      ld_en = 1'b0;

      // Single fetch of 0x8, with explicit per-cycle handshake checks
      req = 1'b1; addr = 32'h8;
      tick();
      req = 1'b0; addr = 32'h0;
      chk("f8_c1_ready", {31'd0, ready}, 32'd0);
      chk("f8_c1_rsp", {31'd0, rsp_valid}, 32'd0);
      tick();
      chk("f8_c2_ready", {31'd0, ready}, 32'd0);
      chk("f8_c2_rsp", {31'd0, rsp_valid}, 32'd0);
      tick();
      chk("f8_c3_rsp", {31'd0, rsp_valid}, 32'd1);
      chk("f8_c3_inst", inst, 32'h0109_5020);
      chk("f8_c3_err", {31'd0, err}, 32'd0);
      chk("f8_c3_ready", {31'd0, ready}, 32'd1);
      tick();
      chk("f8_c4_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("f8_c4_inst_hold", inst, 32'h0109_5020);

      // Req held high, address stepping at each acceptance
      n_rsp = 0; n_acc = 0; last_cyc = 0;
      req = 1'b1; addr = 32'h0;
      for (int c = 1; c <= 16; c++) begin
         rdy_before = ready;
         tick();
         if (rdy_before && req) begin
            n_acc++;
            addr = 32'(n_acc * 4);
            if (n_acc == 4) req = 1'b0;
         end
         if (rsp_valid) begin
            if (n_rsp < 4) chk($sformatf("stream_inst%0d", n_rsp), inst, prog[n_rsp]);
            if (n_rsp > 0) chk($sformatf("stream_gap%0d", n_rsp), 32'(c - last_cyc), 32'd3);
            last_cyc = c;
            n_rsp++;
         end
      end
      chk("stream_count", 32'(n_rsp), 32'd4);
      req = 1'b0;

      fetch_check("misalign", 32'h6, 32'h0, 1'b1);
      fetch_check("oor", 32'h100, 32'h0, 1'b1);
      fetch_check("valid_after_err", 32'hC, 32'h0800_0000, 1'b0);
      fetch_check("last_word", 32'hFC, 32'h1234_5678, 1'b0);

      // Load to the word being fetched in the acceptance cycle returns the old word
      req = 1'b1; addr = 32'h4;
      ld_en = 1'b1; ld_addr = 6'd1; ld_data = 32'hDEAD_BEEF;
      tick();
      req = 1'b0; ld_en = 1'b0;
      tick();
      tick();
      chk("rbw_rsp", {31'd0, rsp_valid}, 32'd1);
      chk("rbw_old", inst, 32'h2009_0003);
      tick();
      fetch_check("rbw_new", 32'h4, 32'hDEAD_BEEF, 1'b0);

      // Reset one cycle after acceptance abandons the fetch
      req = 1'b1; addr = 32'h8;
      tick();
      req = 1'b0;
      rst = 1'b1;
      tick();
      chk("midrst_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("midrst_ready", {31'd0, ready}, 32'd0);
      chk("midrst_inst", inst, 32'h0);
      chk("midrst_err", {31'd0, err}, 32'd0);
      rst = 1'b0;
      tick();
      chk("midrst_ready_up", {31'd0, ready}, 32'd1);
      n_rsp = 0;
      for (int c = 0; c < 4; c++) begin
         if (rsp_valid) n_rsp++;
         tick();
      end
      chk("midrst_no_rsp", 32'(n_rsp), 32'd0);
      fetch_check("midrst_keep", 32'hC, 32'h0800_0000, 1'b0);

      // Zero-wait-state instance, Req held high
      exp0[0] = 32'h2008_0005;
      exp0[1] = 32'hDEAD_BEEF;
      exp0[2] = 32'h0109_5020;
      exp0[3] = 32'h0800_0000;
      chk("w0_ready_idle", {31'd0, ready0}, 32'd1);
      req0 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         addr0 = 32'(i * 4);
         tick();
         chk($sformatf("w0_rsp%0d", i), {31'd0, rsp_valid0}, 32'd1);
         chk($sformatf("w0_inst%0d", i), inst0, exp0[i]);
         chk($sformatf("w0_ready%0d", i), {31'd0, ready0}, 32'd1);
         chk($sformatf("w0_err%0d", i), {31'd0, err0}, 32'd0);
      end
      req0 = 1'b0;
      tick();
      chk("w0_rsp_end", {31'd0, rsp_valid0}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
